acc_dump: RTL and testbench

//   Frame transmitter between the accumulator and the UART transmitter. On a start pulse it

---
 rtl/acc_dump.sv | 123 ++++++++++++
 tb/tb_acc_dump.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_dump.sv
// Frame transmitter: snapshots the accumulator on start and feeds it to the UART
// as HEADER, payload bytes MSB first, then an 8-bit additive checksum of the payload.
module acc_dump #(
    parameter int          WIDTH  = 128,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] big,
    input  logic             busy,
    output logic             transmit,
    output logic [7:0]       data_tx,
    output logic             active,
    output logic             done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = $clog2(NBYTES + 2);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  snapshot_q, snapshot_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              transmit_q, transmit_d;
    logic [7:0]        data_tx_q, data_tx_d;
    logic [7:0]        cur_byte;
    logic              is_payload;

    // The snapshot is shifted left after each payload byte, so the next byte is always at the top.
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        transmit_d = 1'b0;
        data_tx_d  = data_tx_q;
        is_payload = (idx_q != '0) && (idx_q != LAST_IDX);
        cur_byte   = snapshot_q[WIDTH-1 -: 8];
        if (idx_q == '0) begin
            cur_byte = HEADER;
        end else if (idx_q == LAST_IDX) begin
            cur_byte = csum_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    snapshot_d = big;
                    idx_d      = '0;
                    csum_d     = 8'h00;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!busy) begin
                    transmit_d = 1'b1;
                    data_tx_d  = cur_byte;
                    state_d    = WAIT_HI;
                    if (is_payload) begin
                        csum_d     = csum_q + cur_byte;
                        snapshot_d = snapshot_q << 8;
                    end
                end
            end
            // Waiting for busy to rise first avoids mistaking the UART's pre-latency idle for completion.
            WAIT_HI: begin
                if (busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDXW'(1);
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            snapshot_q <= '0;
            idx_q      <= '0;
            csum_q     <= 8'h00;
            transmit_q <= 1'b0;
            data_tx_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            transmit_q <= transmit_d;
            data_tx_q  <= data_tx_d;
        end
    end

    assign transmit = transmit_q;
    assign data_tx  = data_tx_q;
    assign active   = (state_q == SEND) || (state_q == WAIT_HI) || (state_q == WAIT_LO);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_acc_dump.sv
// Self-checking bench for acc_dump: UART busy model, byte monitor and a frame
// reference model built from the byte/checksum rules with plain arithmetic.
module tb_acc_dump;

    localparam int W = 128;

    typedef logic [7:0] byte_q_t[$];
    typedef int         int_q_t[$];

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   big;
    logic           busy;
    logic           transmit;
    logic [7:0]     data_tx;
    logic           active;
    logic           done;

    logic           start8;
    logic [7:0]     big8;
    logic           busy8;
    logic           transmit8;
    logic [7:0]     data_tx8;
    logic           active8;
    logic           done8;

    logic           busy_force;
    int             busy_len  = 10;
    int             busy_len8 = 1;
    int             uart_cnt  = 0;
    int             uart_cnt8 = 0;

    int             cyc = 0;
    int             start_cyc;
    byte_q_t        got_q;
    int_q_t         tx_cyc_q;
    int             done_cnt = 0;
    byte_q_t        got8_q;
    int_q_t         tx_cyc8_q;
    int             done_cnt8 = 0;
    byte_q_t        exp_q;

    int             tests = 0;
    int             fails = 0;

    always #5 clk = ~clk;

    acc_dump #(.WIDTH(W), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .big(big), .busy(busy),
        .transmit(transmit), .data_tx(data_tx), .active(active), .done(done)
    );

    acc_dump #(.WIDTH(8), .HEADER(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .big(big8), .busy(busy8),
        .transmit(transmit8), .data_tx(data_tx8), .active(active8), .done(done8)
    );

    // UART model: busy rises the cycle after a transmit pulse and stays high busy_len cycles.
    always @(posedge clk) begin
        if (transmit) uart_cnt <= busy_len;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
        if (transmit8) uart_cnt8 <= busy_len8;
        else if (uart_cnt8 > 0) uart_cnt8 <= uart_cnt8 - 1;
    end

    assign busy  = busy_force | (uart_cnt != 0);
    assign busy8 = (uart_cnt8 != 0);

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (transmit) begin
                got_q.push_back(data_tx);
                tx_cyc_q.push_back(cyc);
            end
            if (done) done_cnt++;
            if (transmit8) begin
                got8_q.push_back(data_tx8);
                tx_cyc8_q.push_back(cyc);
            end
            if (done8) done_cnt8++;
        end
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, payload MSB first, then payload sum mod 256.
    task automatic build_expected(input logic [W-1:0] v, input int nb);
        int         sum;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        sum = 0;
        for (int i = 0; i < nb; i++) begin
            b = 8'((v >> (8 * (nb - 1 - i))) & 128'hFF);
            exp_q.push_back(b);
            sum = sum + int'(b);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic check_frame(input string tag, input byte_q_t g, input int_q_t cycs, input int dcnt);
        int mg;
        check_output({tag, " len"}, W'(g.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < g.size()) check_output($sformatf("%s byte%0d", tag, i), W'(g[i]), W'(exp_q[i]));
        end
        check_output({tag, " done count"}, W'(dcnt), W'(1));
        mg = 1000;
        for (int i = 1; i < cycs.size(); i++) begin
            if (cycs[i] - cycs[i-1] < mg) mg = cycs[i] - cycs[i-1];
        end
        check_output({tag, " gap>=3"}, W'(mg >= 3), W'(1));
    endtask

    task automatic apply_stimulus(input logic [W-1:0] v);
        @(negedge clk);
        got_q.delete();
        tx_cyc_q.delete();
        done_cnt  = 0;
        big       = v;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        big   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_frame_end(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " finished"}, W'(n < 3000), W'(1));
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_bytes(input int count, input string tag);
        int n;
        n = 0;
        while (got_q.size() < count && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " reached byte"}, W'(n < 2000), W'(1));
    endtask

    initial begin
        logic [W-1:0] v;
        int           f;
        int           n;

        rst        = 1'b1;
        start      = 1'b0;
        big        = '0;
        start8     = 1'b0;
        big8       = 8'h00;
        busy_force = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset transmit", W'(transmit), W'(0));
        check_output("reset data_tx", W'(data_tx), W'(0));
        check_output("reset active", W'(active), W'(0));
        check_output("reset done", W'(done), W'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Counting pattern with a 10-cycle busy UART
        busy_len = 10;
        v = 128'h000102030405060708090A0B0C0D0E0F;
        apply_stimulus(v);
        check_output("t1 active after start", W'(active), W'(1));
        wait_frame_end("t1");
        build_expected(v, 16);
        check_output("t1 csum", W'(exp_q[17]), W'(8'h78));
        check_frame("t1", got_q, tx_cyc_q, done_cnt);
        if (tx_cyc_q.size() > 0) check_output("t1 latency", W'(tx_cyc_q[0] - start_cyc), W'(2));
        check_output("t1 active idle", W'(active), W'(0));

        // All-ones payload checks checksum wrap
        busy_len = 3;
        v = {W{1'b1}};
        apply_stimulus(v);
        wait_frame_end("t2");
        build_expected(v, 16);
        check_frame("t2", got_q, tx_cyc_q, done_cnt);
        if (got_q.size() == 18) check_output("t2 last byte", W'(got_q[17]), W'(8'hF0));

        // Busy stuck high at start
        busy_len   = 10;
        busy_force = 1'b1;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(v);
        repeat (20) @(negedge clk);
        check_output("t3 no tx while busy", W'(got_q.size()), W'(0));
        busy_force = 1'b0;
        f = cyc;
        n = 0;
        while (got_q.size() == 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_output("t3 first tx seen", W'(got_q.size() > 0), W'(1));
        if (got_q.size() > 0) begin
            check_output("t3 first tx cycle", W'(tx_cyc_q[0] - f), W'(1));
            check_output("t3 first byte", W'(got_q[0]), W'(8'hA5));
        end
        wait_frame_end("t3");
        build_expected(v, 16);
        check_frame("t3", got_q, tx_cyc_q, done_cnt);

        // Second start mid-frame is ignored
        busy_len = 4;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(v);
        wait_bytes(5, "t4");
        big   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frame_end("t4");
        build_expected(v, 16);
        check_frame("t4", got_q, tx_cyc_q, done_cnt);

        // Reset during WAIT_LO of byte 9
        busy_len = 10;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(v);
        wait_bytes(9, "t5");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("t5 rst transmit", W'(transmit), W'(0));
        check_output("t5 rst data_tx", W'(data_tx), W'(0));
        check_output("t5 rst active", W'(active), W'(0));
        check_output("t5 rst done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_output("t5 no resend", W'(got_q.size()), W'(9));
        check_output("t5 no done", W'(done_cnt), W'(0));
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(v);
        wait_frame_end("t5 new");
        build_expected(v, 16);
        check_frame("t5 new", got_q, tx_cyc_q, done_cnt);

        // Random payloads with random UART busy lengths
        for (int k = 0; k < 3; k++) begin
            busy_len = int'($urandom_range(1, 12));
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
            apply_stimulus(v);
            wait_frame_end($sformatf("rnd%0d", k));
            build_expected(v, 16);
            check_frame($sformatf("rnd%0d", k), got_q, tx_cyc_q, done_cnt);
        end

        // Minimal width with a one-cycle busy UART
        busy_len8 = 1;
        @(negedge clk);
        got8_q.delete();
        tx_cyc8_q.delete();
        done_cnt8 = 0;
        big8   = 8'h3C;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        big8   = 8'($urandom());
        n = 0;
        while (done_cnt8 == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_output("t6 finished", W'(n < 500), W'(1));
        repeat (5) @(negedge clk);
        build_expected(W'(8'h3C), 1);
        check_frame("t6", got8_q, tx_cyc8_q, done_cnt8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
